test_snap_seq: RTL

TEST_SNAP_SEQ -- requirements
Module: test_snap_seq

---
 rtl/test_snap_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/test_snap_seq.sv
// Test-mode snapshot sequencer: captures five live channel outputs every INTERVAL+2 cycles while LOCK is set.
// Latency: first capture INTERVAL+1 cycles after the LOCK write; read data and RD_ACK one cycle after RD_REQ.
// Backpressure: none; every request is acknowledged, and back-to-back requests give back-to-back acknowledges.
module test_snap_seq (
    input  logic       ACLK1,
    input  logic       n_RES,
    input  logic       W401A,
    input  logic [7:0] DB_in,
    input  logic       RD_REQ,
    input  logic [1:0] RD_SEL,
    input  logic [3:0] SQA_in,
    input  logic [3:0] SQB_in,
    input  logic [3:0] TRI_in,
    input  logic [3:0] RND_in,
    input  logic [6:0] DMC_in,
    output logic       LOCK,
    output logic [7:0] DB_out,
    output logic       DB_oe,
    output logic       RD_ACK,
    output logic       SNAP_VALID
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lock_q, lock_d;
    logic [3:0] interval_q, interval_d;
    logic [3:0] s_sqa_q, s_sqa_d;
    logic [3:0] s_sqb_q, s_sqb_d;
    logic [3:0] s_tri_q, s_tri_d;
    logic [3:0] s_rnd_q, s_rnd_d;
    logic [6:0] s_dmc_q, s_dmc_d;
    logic       snap_valid_q, snap_valid_d;
    logic       rd_ack_q, rd_ack_d;
    logic [7:0] db_out_q, db_out_d;

    logic       lock_eff;
    logic [3:0] interval_eff;
    logic       capture;
    logic       rd_clr;
    logic [7:0] rd_dat;
    logic       db_unused;

    assign db_unused = ^DB_in[6:4];

    // A write takes effect on its own edge, so the FSM sees the incoming control value.
    always_comb begin
        lock_eff     = W401A ? DB_in[7]   : lock_q;
        interval_eff = W401A ? DB_in[3:0] : interval_q;
        lock_d       = lock_eff;
        interval_d   = interval_eff;
    end

    assign capture = (state_q == ST_RUN) && (cnt_q == 4'd0);

    // A capture always completes, even if a write lands on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (lock_eff) begin
                    state_d = ST_RUN;
                    cnt_d   = interval_eff;
                end
            end
            ST_RUN: begin
                if (capture) begin
                    state_d = ST_CAPT;
                end else if (!lock_eff) begin
                    state_d = ST_IDLE;
                end else if (W401A) begin
                    cnt_d = interval_eff;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPT: begin
                if (!lock_eff) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = interval_eff;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_sqa_d = capture ? SQA_in : s_sqa_q;
        s_sqb_d = capture ? SQB_in : s_sqb_q;
        s_tri_d = capture ? TRI_in : s_tri_q;
        s_rnd_d = capture ? RND_in : s_rnd_q;
        s_dmc_d = capture ? DMC_in : s_dmc_q;
    end

    assign rd_clr = RD_REQ && (RD_SEL == 2'd2);

    always_comb begin
        snap_valid_d = snap_valid_q;
        if (capture) begin
            snap_valid_d = 1'b1;
        end else if (rd_clr) begin
            snap_valid_d = 1'b0;
        end
    end

    // Read data comes from pre-edge shadow state, so a read never sees a half-updated snapshot.
    always_comb begin
        rd_dat = 8'h00;
        case (RD_SEL)
            2'd0:    rd_dat = {s_sqb_q, s_sqa_q};
            2'd1:    rd_dat = {s_rnd_q, s_tri_q};
            2'd2:    rd_dat = {1'b0, s_dmc_q};
            default: rd_dat = {lock_q, snap_valid_q, 2'b00, interval_q};
        endcase
        rd_ack_d = RD_REQ;
        db_out_d = RD_REQ ? rd_dat : 8'h00;
    end

    always_ff @(posedge ACLK1 or negedge n_RES) begin
        if (!n_RES) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            lock_q       <= 1'b0;
            interval_q   <= 4'd0;
            s_sqa_q      <= 4'd0;
            s_sqb_q      <= 4'd0;
            s_tri_q      <= 4'd0;
            s_rnd_q      <= 4'd0;
            s_dmc_q      <= 7'd0;
            snap_valid_q <= 1'b0;
            rd_ack_q     <= 1'b0;
            db_out_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lock_q       <= lock_d;
            interval_q   <= interval_d;
            s_sqa_q      <= s_sqa_d;
            s_sqb_q      <= s_sqb_d;
            s_tri_q      <= s_tri_d;
            s_rnd_q      <= s_rnd_d;
            s_dmc_q      <= s_dmc_d;
            snap_valid_q <= snap_valid_d;
            rd_ack_q     <= rd_ack_d;
            db_out_q     <= db_out_d;
        end
    end

    assign LOCK       = lock_q;
    assign DB_out     = db_out_q;
    assign DB_oe      = rd_ack_q;
    assign RD_ACK     = rd_ack_q;
    assign SNAP_VALID = snap_valid_q;

endmodule
